mips_multicycle_ctrl: RTL and testbench

- Multi-cycle MIPS main controller. Replaces the single-cycle opcode decoder with a Moore FSM that sequences fetch/decode/execute/memory/writeback over several cycles.
- Drives datapath mux selects, register-file and memory strobes, and PC update.
- Waits on a memory ready handshake with a bounded timeout.
- Raises a sticky exception on an illegal opcode or a memory timeout.

---
 rtl/mips_ctrl_pkg.sv | 56 +++++
 rtl/mips_multicycle_ctrl_timer.sv | 29 ++
 rtl/mips_multicycle_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller.
package mips_ctrl_pkg;

  // FSM state encodings (also exported on the debug state port)
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    R_EX     = 4'd7,
    R_WB     = 4'd8,
    I_EX     = 4'd9,
    I_WB     = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12,
    EXC      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_SLT   = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_RT     = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_t;

  typedef enum logic [1:0] {
    EXC_NONE    = 2'b00,
    EXC_ILLEGAL = 2'b01,
    EXC_TIMEOUT = 2'b10
  } exc_cause_t;

endpackage

// File: rtl/mips_multicycle_ctrl_timer.sv
// Memory-wait timer: counts not-ready cycles since the last start and
// flags the cycle on which the wait budget is exhausted.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TIMEOUT_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ready,
  output logic timeout
);

  logic [TIMEOUT_W-1:0] wait_cnt;

  // Clear on start (entry into a waiting state), otherwise count stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         wait_cnt <= '0;
    else if (start)  wait_cnt <= '0;
    else if (!ready) wait_cnt <= wait_cnt + 1'b1;
  end

  // Ready on the limit cycle wins; MEM_TIMEOUT of 0 disables the check
  always_comb begin
    timeout = (MEM_TIMEOUT != 0) && !ready &&
              (wait_cnt == TIMEOUT_W'(MEM_TIMEOUT));
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main controller (Moore FSM with memory wait timeout).
// Optional: define MCTRL_PERF_CNT_EN to enable cycle/instruction counters;
// otherwise cycle_cnt and instr_cnt are tied to zero.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 6,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TIMEOUT_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_src,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic [1:0]          alu_op,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                instr_done,
  output logic                exception,
  output logic [1:0]          exc_cause,
  output logic [3:0]          state,
  output logic [31:0]         cycle_cnt,
  output logic [31:0]         instr_cnt
);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q;
  logic [1:0]          cause_q, cause_d;
  logic                timeout, wait_start;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TIMEOUT_W   (TIMEOUT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (wait_start),
    .ready   (mem_ready),
    .timeout (timeout)
  );

  // State, latched opcode and exception cause registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (state_q == DECODE) op_q <= opcode;
    end
  end

  // Next-state logic, including exception entry
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (mem_ready) state_d = DECODE;
        else if (timeout) begin
          state_d = EXC;
          cause_d = EXC_TIMEOUT;
        end
      end
      DECODE: begin
        if (opcode == OPCODE_W'(OP_RTYPE))     state_d = R_EX;
        else if (opcode == OPCODE_W'(OP_ADDI) ||
                 opcode == OPCODE_W'(OP_SLTI)) state_d = I_EX;
        else if (opcode == OPCODE_W'(OP_LW) ||
                 opcode == OPCODE_W'(OP_SW))   state_d = MEM_ADDR;
        else if (opcode == OPCODE_W'(OP_BEQ))  state_d = BRANCH;
        else if (opcode == OPCODE_W'(OP_J))    state_d = JUMP;
        else begin
          state_d = EXC;
          cause_d = EXC_ILLEGAL;
        end
      end
      MEM_ADDR: state_d = (op_q == OPCODE_W'(OP_SW)) ? MEM_WR : MEM_RD;
      MEM_RD, MEM_WR: begin
        if (mem_ready) state_d = (state_q == MEM_RD) ? MEM_WB : FETCH;
        else if (timeout) begin
          state_d = EXC;
          cause_d = EXC_TIMEOUT;
        end
      end
      MEM_WB, R_WB, I_WB, BRANCH, JUMP: state_d = FETCH;
      R_EX: state_d = R_WB;
      I_EX: state_d = I_WB;
      EXC:  state_d = EXC;
      default: begin
        state_d = EXC;
        cause_d = EXC_ILLEGAL;
      end
    endcase
  end

  // Timer restarts only when a waiting state is freshly entered
  always_comb begin
    wait_start = (state_d == FETCH || state_d == MEM_RD || state_d == MEM_WR) &&
                 (state_d != state_q);
  end

  // Moore output decode; a few strobes are qualified by mem_ready
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PC_ALU;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    alu_op        = ALU_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    instr_done    = 1'b0;
    exception     = 1'b0;
    exc_cause     = EXC_NONE;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE:   alu_src_b = SRCB_IMM_SH;
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      R_EX: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      I_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = (op_q == OPCODE_W'(OP_SLTI)) ? ALU_SLT : ALU_ADD;
      end
      I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PC_ALUOUT;
        instr_done    = 1'b1;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_src     = PC_JUMP;
        instr_done = 1'b1;
      end
      EXC: begin
        exception = 1'b1;
        exc_cause = cause_q;
      end
      default: ;
    endcase
  end

  assign state = state_q;

`ifdef MCTRL_PERF_CNT_EN
  logic [31:0] cycle_q, instr_q;

  // Active-cycle and retired-instruction counters, wrapping at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      if (state_q != IDLE && state_q != EXC) cycle_q <= cycle_q + 32'd1;
      if (instr_done)                        instr_q <= instr_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: instruction-level reference
// model with randomized opcodes, memory stalls, timeouts and reset aborts.
module tb_mips_multicycle_ctrl;

  localparam int TMO = 15;
`ifdef MCTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // state numbering as published on the debug port
  localparam int T_IDLE = 0, T_FETCH = 1, T_DECODE = 2, T_MEM_ADDR = 3,
                 T_MEM_RD = 4, T_MEM_WB = 5, T_MEM_WR = 6, T_R_EX = 7,
                 T_R_WB = 8, T_I_EX = 9, T_I_WB = 10, T_BRANCH = 11,
                 T_JUMP = 12, T_EXC = 13;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, alu_src_a, reg_write, reg_dst, instr_done, exception;
  logic [1:0]  pc_src, alu_op, alu_src_b, exc_cause;
  logic [3:0]  state;
  logic [31:0] cycle_cnt, instr_cnt;
  logic [23:0] dut_vec;

  int n_checks = 0;
  int n_err    = 0;
  int m_cyc    = 0;
  int m_ins    = 0;
  logic [5:0] cur_op;
  logic [1:0] exp_cause;

  mips_multicycle_ctrl #(
    .OPCODE_W    (6),
    .MEM_TIMEOUT (TMO),
    .TIMEOUT_W   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_src        (pc_src),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .alu_op        (alu_op),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .instr_done    (instr_done),
    .exception     (exception),
    .exc_cause     (exc_cause),
    .state         (state),
    .cycle_cnt     (cycle_cnt),
    .instr_cnt     (instr_cnt)
  );

  always #5 clk = ~clk;

  assign dut_vec = {pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
                    ir_write, mem_to_reg, alu_op, alu_src_a, alu_src_b, reg_write,
                    reg_dst, instr_done, exception, exc_cause, state};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected control word for a state, straight from the per-state table
  function automatic logic [23:0] exp_out(input int st, input bit rdy,
                                          input logic [5:0] op, input logic [1:0] cause);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd, done, exc;
    logic [1:0] psrc, aop, asb, ec;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd, done, exc} = '0;
    {psrc, aop, asb, ec} = '0;
    case (st)
      T_FETCH:    begin mrd = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      T_DECODE:   asb = 2'b11;
      T_MEM_ADDR: begin asa = 1; asb = 2'b10; end
      T_MEM_RD:   begin mrd = 1; iord = 1; end
      T_MEM_WB:   begin rw = 1; m2r = 1; done = 1; end
      T_MEM_WR:   begin mwr = 1; iord = 1; done = rdy; end
      T_R_EX:     begin asa = 1; aop = 2'b10; end
      T_R_WB:     begin rw = 1; rd = 1; done = 1; end
      T_I_EX:     begin asa = 1; asb = 2'b10; aop = (op == 6'b001010) ? 2'b11 : 2'b00; end
      T_I_WB:     begin rw = 1; done = 1; end
      T_BRANCH:   begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; done = 1; end
      T_JUMP:     begin pcw = 1; psrc = 2'b10; done = 1; end
      T_EXC:      begin exc = 1; ec = cause; end
      default: ;
    endcase
    return {pcw, pcwc, psrc, iord, mrd, mwr, irw, m2r, aop, asa, asb, rw, rd,
            done, exc, ec, 4'(st)};
  endfunction

  // One clock: drive ready, check at negedge, advance the counter model
  task automatic tick(input int st, input bit rdy, input string tag);
    logic [23:0] e;
    mem_ready = rdy;
    e = exp_out(st, rdy, cur_op, exp_cause);
    @(negedge clk);
    check(tag, 32'(dut_vec), 32'(e));
    check({tag, "_cyc"}, cycle_cnt, PERF ? 32'(m_cyc) : 32'd0);
    check({tag, "_ins"}, instr_cnt, PERF ? 32'(m_ins) : 32'd0);
    @(posedge clk);
    #1;
    if (st != T_IDLE && st != T_EXC) m_cyc++;
    if (e[7]) m_ins++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_async", 32'(dut_vec), 32'd0);
    check("rst_cyc", cycle_cnt, 32'd0);
    check("rst_ins", instr_cnt, 32'd0);
    m_cyc = 0;
    m_ins = 0;
    exp_cause = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'($urandom);
    #1;
    check("idle", 32'(dut_vec), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Memory wait: ready after d stalled cycles, unless the budget runs out
  task automatic do_wait(input int st, input int d, input string tag, output bit timed_out);
    timed_out = 1'b0;
    for (int c = 0; c <= TMO; c++) begin
      bit r;
      r = (c >= d);
      tick(st, r, tag);
      if (r) break;
      if (c == TMO) timed_out = 1'b1;
    end
  endtask

  task automatic exc_phase(input logic [1:0] cause, input int n);
    exp_cause = cause;
    for (int i = 0; i < n; i++) tick(T_EXC, 1'($urandom), "exc");
    do_reset();
  endtask

  task automatic run_instr(input logic [5:0] op, input int fd, input int md,
                           input bit abort, input int exc_len);
    bit to;
    opcode = op;
    cur_op = op;
    do_wait(T_FETCH, fd, "fetch", to);
    if (to) begin exc_phase(2'b10, exc_len); return; end
    tick(T_DECODE, 1'($urandom), "decode");
    opcode = 6'($urandom);
    if (abort) begin do_reset(); return; end
    case (op)
      6'b000000: begin tick(T_R_EX, 1'($urandom), "r_ex"); tick(T_R_WB, 1'($urandom), "r_wb"); end
      6'b001000, 6'b001010: begin
        tick(T_I_EX, 1'($urandom), "i_ex");
        tick(T_I_WB, 1'($urandom), "i_wb");
      end
      6'b100011: begin
        tick(T_MEM_ADDR, 1'($urandom), "mem_addr");
        do_wait(T_MEM_RD, md, "mem_rd", to);
        if (to) exc_phase(2'b10, exc_len);
        else tick(T_MEM_WB, 1'($urandom), "mem_wb");
      end
      6'b101011: begin
        tick(T_MEM_ADDR, 1'($urandom), "mem_addr");
        do_wait(T_MEM_WR, md, "mem_wr", to);
        if (to) exc_phase(2'b10, exc_len);
      end
      6'b000100: tick(T_BRANCH, 1'($urandom), "branch");
      6'b000010: tick(T_JUMP, 1'($urandom), "jump");
      default:   exc_phase(2'b01, exc_len);
    endcase
  endtask

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 19);
    if (r < 14) return r % 4;
    if (r < 16) return TMO;
    if (r < 17) return TMO + 1 + $urandom_range(0, 3);
    return $urandom_range(4, 8);
  endfunction

  initial begin
    logic [5:0] legal [7];
    logic [5:0] op;
    legal = '{6'b000000, 6'b001000, 6'b001010, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
    rst = 1'b1;
    mem_ready = 1'b0;
    opcode = '0;
    cur_op = '0;
    exp_cause = 2'b00;
    @(posedge clk);
    #1;
    do_reset();

    // directed: R-type, stalled LW, BEQ, J, illegal opcode, FETCH timeout edges
    run_instr(6'b000000, 0, 0, 1'b0, 4);
    run_instr(6'b100011, 0, 3, 1'b0, 4);
    run_instr(6'b000100, 0, 0, 1'b0, 4);
    run_instr(6'b000010, 0, 0, 1'b0, 4);
    run_instr(6'b111111, 0, 0, 1'b0, 20);
    run_instr(6'b000000, TMO + 1, 0, 1'b0, 5);
    run_instr(6'b000000, TMO, 0, 1'b0, 4);
    run_instr(6'b101011, 0, TMO + 1, 1'b0, 3);
    foreach (legal[i]) if (i != 0 && i != 5) run_instr(legal[i], 0, 0, 1'b0, 4);

    // randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else op = legal[$urandom_range(0, 6)];
      run_instr(op, pick_delay(), pick_delay(), $urandom_range(0, 15) == 0,
                $urandom_range(1, 4));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
